// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: scans up to NR_SENSORS sensors on a shared bus, sums
// acknowledged temperatures, counts them, and divides for a truncated average.
// Ports: clk_i, rst_n_i (async low), start_i, sensors_en_i (mask captured at
// start), sens_req_o/sens_sel_o/sens_data_i/sens_ack_i (sensor bus),
// busy_o, done_o, temp_sum_o, nr_active_sensors_o, temp_avg_o, timeout_mask_o.
module sensor_scan_ctrl #(
  parameter int NR_SENSORS = 5,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [NR_SENSORS-1:0] sensors_en_i,
  output logic                  sens_req_o,
  output logic [2:0]            sens_sel_o,
  input  logic [DATA_W-1:0]     sens_data_i,
  input  logic                  sens_ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           temp_sum_o,
  output logic [7:0]            nr_active_sensors_o,
  output logic [DATA_W-1:0]     temp_avg_o,
  output logic [NR_SENSORS-1:0] timeout_mask_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST = 3'(NR_SENSORS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_DIVIDE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NR_SENSORS-1:0] en_q, en_d;
  logic [2:0]            idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [15:0]           acc_q, acc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NR_SENSORS-1:0] wmask_q, wmask_d;
  logic [15:0]           rem_q, rem_d;
  logic [15:0]           quo_q, quo_d;
  logic [3:0]            dcnt_q, dcnt_d;
  logic [15:0]           sum_q, sum_d;
  logic [7:0]            nact_q, nact_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic [NR_SENSORS-1:0] tmask_q, tmask_d;

  logic        advance;
  logic [16:0] trial;
  logic        ge;
  logic [15:0] diff;
  logic [15:0] div_quo;

  // One restoring division step; the remainder is always below the
  // divisor (<= 255), so 16 bits hold it.
  assign trial   = {rem_q, quo_q[15]};
  assign ge      = trial >= 17'(cnt_q);
  assign diff    = trial[15:0] - 16'(cnt_q);
  assign div_quo = {quo_q[14:0], ge};

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wmask_d = wmask_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dcnt_d  = dcnt_q;
    sum_d   = sum_q;
    nact_d  = nact_q;
    avg_d   = avg_q;
    tmask_d = tmask_q;
    advance = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          en_d    = sensors_en_i;
          acc_d   = '0;
          cnt_d   = '0;
          wmask_d = '0;
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (en_q[idx_q]) begin
          wait_d  = '0;
          state_d = S_REQ;
        end else begin
          advance = 1'b1;
        end
      end
      S_REQ: begin
        wait_d = wait_q + WAIT_W'(1);
        if (sens_ack_i) begin
          acc_d   = acc_q + 16'(sens_data_i);
          cnt_d   = cnt_q + 8'd1;
          advance = 1'b1;
        end else if (wait_q == WAIT_LIM) begin
          wmask_d[idx_q] = 1'b1;
          advance        = 1'b1;
        end
      end
      S_DIVIDE: begin
        if (cnt_q == 8'd0) begin
          sum_d   = '0;
          nact_d  = '0;
          avg_d   = '0;
          tmask_d = wmask_q;
          state_d = S_DONE;
        end else begin
          rem_d  = ge ? diff : trial[15:0];
          quo_d  = div_quo;
          dcnt_d = dcnt_q + 4'd1;
          if (dcnt_q == 4'hF) begin
            sum_d   = acc_q;
            nact_d  = cnt_q;
            avg_d   = div_quo[DATA_W-1:0];
            tmask_d = wmask_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving a sensor: next index, or start the divide after the last.
    if (advance) begin
      if (idx_q == LAST) begin
        quo_d   = acc_d;
        rem_d   = '0;
        dcnt_d  = '0;
        state_d = S_DIVIDE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = S_SELECT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wmask_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
      sum_q   <= '0;
      nact_q  <= '0;
      avg_q   <= '0;
      tmask_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wmask_q <= wmask_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dcnt_q  <= dcnt_d;
      sum_q   <= sum_d;
      nact_q  <= nact_d;
      avg_q   <= avg_d;
      tmask_q <= tmask_d;
    end
  end

  assign sens_req_o          = (state_q == S_REQ);
  assign sens_sel_o          = sens_req_o ? idx_q : 3'd0;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign temp_sum_o          = sum_q;
  assign nr_active_sensors_o = nact_q;
  assign temp_avg_o          = avg_q;
  assign timeout_mask_o      = tmask_q;

endmodule
